// File: rtl/isqrt_stage_if.sv
// rtl/isqrt_stage_if.sv - radicand/result handshake bundle for isqrt_stage
interface isqrt_stage_if #(
   parameter int IN_W = 16
);
   localparam int OUT_W = IN_W / 2;

   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic [OUT_W:0]   out_rem;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_rem
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_rem
   );
endinterface

// File: rtl/isqrt_stage.sv
// rtl/isqrt_stage.sv - iterative restoring integer square root, one root bit per enabled edge
// Optional ISQRT_ROUND_EN: round root to nearest (saturating); remainder stays the floor remainder.
module isqrt_stage #(
   parameter int IN_W = 16
) (
   input logic          clk,
   input logic          rst,
   input logic          ena,
   isqrt_stage_if.slave bus
);
   localparam int OUT_W = IN_W / 2;
   localparam int CNT_W = $clog2(OUT_W + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(OUT_W - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [IN_W-1:0]  rad;
   logic [OUT_W-1:0] root;
   logic [OUT_W:0]   rem;
   logic [CNT_W-1:0] cnt;
   logic [OUT_W-1:0] res_data;
   logic [OUT_W:0]   res_rem;

   logic [OUT_W+1:0] rem_t;
   logic [OUT_W+1:0] trial;
   logic [OUT_W+1:0] rem_sel;
   logic [OUT_W-1:0] root_next;
   logic [OUT_W:0]   rem_next;
   logic [OUT_W-1:0] round_data;
   logic             ge;
   logic             take;
   logic             unused_top;

   // Remainder never exceeds 2*root, so only its low OUT_W bits feed the next shift.
   always_comb begin
      rem_t     = {rem[OUT_W-1:0], rad[IN_W-1 -: 2]};
      trial     = {root, 2'b01};
      ge        = (rem_t >= trial);
      rem_sel   = ge ? (rem_t - trial) : rem_t;
      root_next = {root[OUT_W-2:0], ge};
      rem_next  = rem_sel[OUT_W:0];
   end

   assign unused_top = rem_sel[OUT_W+1];

   always_comb begin
      round_data = root_next;
`ifdef ISQRT_ROUND_EN
      if (({1'b0, root_next} < rem_next) && (root_next != '1))
         round_data = root_next + 1'b1;
`endif
   end

   assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
   assign bus.out_valid = (state == DONE);
   assign bus.out_data  = res_data;
   assign bus.out_rem   = res_rem;
   assign take          = ena && bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         rad      <= '0;
         root     <= '0;
         rem      <= '0;
         cnt      <= '0;
         res_data <= '0;
         res_rem  <= '0;
      end else if (ena) begin
         if (take) begin
            // Covers both a fresh accept from IDLE and a pop+accept from DONE.
            state <= BUSY;
            rad   <= bus.in_data;
            root  <= '0;
            rem   <= '0;
            cnt   <= '0;
         end else begin
            case (state)
               BUSY: begin
                  rad  <= {rad[IN_W-3:0], 2'b00};
                  root <= root_next;
                  rem  <= rem_next;
                  cnt  <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     state    <= DONE;
                     res_data <= round_data;
                     res_rem  <= rem_next;
                  end
               end
               DONE: begin
                  if (bus.out_ready)
                     state <= IDLE;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_isqrt_stage.sv
// tb/tb_isqrt_stage.sv - randomized self-checking bench for isqrt_stage against an arithmetic model
module tb_isqrt_stage;
   localparam int IN_W  = 16;
   localparam int OUT_W = IN_W / 2;
   localparam int LAT   = OUT_W;

   logic clk = 1'b0;
   logic rst;
   logic ena;
   int   n_tests = 0;
   int   n_fail  = 0;

   isqrt_stage_if #(.IN_W(IN_W)) bus ();

   isqrt_stage #(.IN_W(IN_W)) dut (
      .clk (clk),
      .rst (rst),
      .ena (ena),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Floor root by search, then optional round-to-nearest with saturation.
   function automatic void ref_sqrt(input int unsigned x, output int unsigned r,
                                    output int unsigned m, output int unsigned o);
      r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      m = x - r * r;
      o = r;
`ifdef ISQRT_ROUND_EN
      if (m > r && r < (1 << OUT_W) - 1) o = r + 1;
`endif
   endfunction

   task automatic wait_done(input bit rand_ena, output int en_cnt);
      int tot;
      en_cnt = 0;
      tot    = 0;
      while (!bus.out_valid && tot < 64) begin
         ena = rand_ena ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(posedge clk); #1;
         tot++;
         if (ena) en_cnt++;
      end
      ena = 1'b1;
      if (!bus.out_valid) check("timeout", 32'd0, 32'd1);
   endtask

   task automatic pop();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("popped", bus.out_valid, 32'd0);
   endtask

   task automatic run_one(input int unsigned x, input bit rand_ena);
      int unsigned r, m, o;
      int en_cnt;
      ref_sqrt(x, r, m, o);
      check("ready_idle", bus.in_ready, 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = x[IN_W-1:0];
      ena          = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("busy_ready", bus.in_ready, 32'd0);
      wait_done(rand_ena, en_cnt);
      check("latency", en_cnt, LAT);
      check("root", bus.out_data, o);
      check("rem", bus.out_rem, m);
      pop();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int unsigned r, m, o;
      int tot;
      logic [OUT_W-1:0] held_d;
      logic [OUT_W:0]   held_r;

      rst           = 1'b1;
      ena           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", bus.out_valid, 32'd0);
      check("rst_data", bus.out_data, 32'd0);
      check("rst_rem", bus.out_rem, 32'd0);
      check("rst_ready", bus.in_ready, 32'd1);
      rst = 1'b0;

      // Directed corner values, then random radicands with random ena gaps
      run_one(0, 1'b0);
      run_one(25, 1'b0);
      run_one(200, 1'b0);
      run_one(65535, 1'b0);
      run_one(210, 1'b0);
      run_one(211, 1'b0);
      run_one(1, 1'b0);
      run_one(255, 1'b0);
      for (int i = 0; i < 30; i++) run_one($urandom_range(0, 65535), 1'b1);

      // Backpressure in DONE with upstream holding the next radicand
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd200;
      @(posedge clk); #1;
      bus.in_data  = 16'd211;
      wait_done(1'b0, tot);
      held_d = bus.out_data;
      held_r = bus.out_rem;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_valid", bus.out_valid, 32'd1);
         check("bp_ready", bus.in_ready, 32'd0);
         check("bp_data", bus.out_data, held_d);
         check("bp_rem", bus.out_rem, held_r);
      end
      ref_sqrt(200, r, m, o);
      check("bp_root", held_d, o);
      check("bp_remv", held_r, m);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      check("pa_valid", bus.out_valid, 32'd0);
      check("pa_busy", bus.in_ready, 32'd0);
      wait_done(1'b0, tot);
      check("pa_latency", tot, LAT);
      ref_sqrt(211, r, m, o);
      check("pa_root", bus.out_data, o);
      check("pa_rem", bus.out_rem, m);
      pop();

      // Enable held low for three edges mid-computation
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd200;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      tot = 0;
      repeat (3) begin @(posedge clk); #1; tot++; end
      ena = 1'b0;
      repeat (3) begin
         @(posedge clk); #1; tot++;
         check("stall_valid", bus.out_valid, 32'd0);
      end
      ena = 1'b1;
      while (!bus.out_valid && tot < 64) begin @(posedge clk); #1; tot++; end
      check("stall_edges", tot, LAT + 3);
      ref_sqrt(200, r, m, o);
      check("stall_root", bus.out_data, o);
      check("stall_rem", bus.out_rem, m);
      pop();

      // Asynchronous reset during iteration 4; previous result must clear at once
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd65535;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      check("ar_valid", bus.out_valid, 32'd0);
      check("ar_ready", bus.in_ready, 32'd1);
      check("ar_data", bus.out_data, 32'd0);
      check("ar_rem", bus.out_rem, 32'd0);
      #2;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd25;
      rst = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("ar_accept", bus.in_ready, 32'd0);
      check("ar_no_stale", bus.out_valid, 32'd0);
      wait_done(1'b0, tot);
      check("ar_latency", tot, LAT);
      check("ar_root", bus.out_data, 32'd5);
      check("ar_rem2", bus.out_rem, 32'd0);
      pop();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
